// File: rtl/store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer
//   Word store buffer between the single-cycle core data port and data
//   memory. Core stores enqueue in one cycle and then drain in program order
//   over a valid/ready write channel. Loads read memory combinationally. The
//   youngest buffered store to the same word overrides the memory data.
//   Stall is raised only when the core stores into a full buffer.
//
// Ports
//   clk, reset           clock; asynchronous active-low reset
//   MemWrite/ALUResult/WriteData   core store request, address, data
//   ReadData             load data to core (forwarded or MemRData)
//   Stall                store not accepted this cycle (buffer full)
//   BufEmpty             no stores pending
//   MemRAdr/MemRData     combinational memory read port
//   MemWValid/MemWReady/MemWAdr/MemWData   write channel (head entry)
// ---------------------------------------------------------------------------
module store_buffer #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [31:0] ALUResult,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Stall,
   output logic        BufEmpty,
   output logic [31:0] MemRAdr,
   input  logic [31:0] MemRData,
   output logic        MemWValid,
   input  logic        MemWReady,
   output logic [31:0] MemWAdr,
   output logic [31:0] MemWData
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] ONE      = (PW+1)'(1);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   // Pointers carry a wrap bit; count is held separately so full/empty
   // come straight from a register.
   logic [PW:0] wr_ptr_q, wr_ptr_d;
   logic [PW:0] rd_ptr_q, rd_ptr_d;
   logic [PW:0] count_q, count_d;

   // Entry RAM, not reset: validity is implied by rd_ptr/count only.
   logic [DEPTH-1:0][29:0] addr_q;
   logic [DEPTH-1:0][31:0] data_q;

   logic          full, empty, enq, deq;
   logic [PW-1:0] wr_idx, rd_idx, fwd_idx;
   logic          unused_addr_lsb;

   assign wr_idx  = wr_ptr_q[PW-1:0];
   assign rd_idx  = rd_ptr_q[PW-1:0];
   assign full    = (count_q == FULL_CNT);
   assign empty   = (count_q == '0);
   assign enq     = MemWrite & ~full;
   assign deq     = ~empty & MemWReady;

   // A pop in the same cycle does not free the slot for this store.
   assign Stall     = MemWrite & full;
   assign BufEmpty  = empty;
   assign MemWValid = ~empty;
   assign MemWAdr   = {addr_q[rd_idx], 2'b00};
   assign MemWData  = data_q[rd_idx];
   assign MemRAdr   = {ALUResult[31:2], 2'b00};
   assign unused_addr_lsb = ^ALUResult[1:0];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (enq) wr_ptr_d = wr_ptr_q + ONE;
      if (deq) rd_ptr_d = rd_ptr_q + ONE;
      case ({enq, deq})
         2'b10:   count_d = count_q + ONE;
         2'b01:   count_d = count_q - ONE;
         default: count_d = count_q;
      endcase
   end

   // Walk entries oldest to youngest; a later match overrides an earlier
   // one, so the youngest store wins. The head being popped still counts.
   always_comb begin
      ReadData = MemRData;
      fwd_idx  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         fwd_idx = rd_idx + PW'(i);
         if (((PW+1)'(i) < count_q) && (addr_q[fwd_idx] == ALUResult[31:2]))
            ReadData = data_q[fwd_idx];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         addr_q[wr_idx] <= ALUResult[31:2];
         data_q[wr_idx] <= WriteData;
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemWrite;
   logic [31:0] ALUResult, WriteData, ReadData, MemRAdr, MemRData;
   logic        Stall, BufEmpty, MemWValid, MemWReady;
   logic [31:0] MemWAdr, MemWData;

   int vectors = 0;
   int miscompares = 0;

   logic [63:0] log_q[$];
   logic [63:0] exp_q[$];

   store_buffer #(.DEPTH(4)) dut (
      .clk(clk), .reset(reset), .MemWrite(MemWrite), .ALUResult(ALUResult),
      .WriteData(WriteData), .ReadData(ReadData), .Stall(Stall),
      .BufEmpty(BufEmpty), .MemRAdr(MemRAdr), .MemRData(MemRData),
      .MemWValid(MemWValid), .MemWReady(MemWReady), .MemWAdr(MemWAdr),
      .MemWData(MemWData)
   );

   always #5 clk = ~clk;

   // Record every accepted write on the memory channel.
   always @(posedge clk)
      if (reset && MemWValid && MemWReady) log_q.push_back({MemWAdr, MemWData});

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      MemWrite = 1'b1; ALUResult = a; WriteData = d;
   endtask

   initial begin
      reset = 1'b0; MemWrite = 1'b0; ALUResult = 32'h0; WriteData = 32'h0;
      MemRData = 32'h1234_5678; MemWReady = 1'b0;

      // 1. reset behaviour
      #1;
      chk("rst_wvalid", {31'b0, MemWValid}, 32'd0);
      chk("rst_empty",  {31'b0, BufEmpty},  32'd1);
      MemWrite = 1'b1; #1;
      chk("rst_stall",  {31'b0, Stall},     32'd0);
      MemWrite = 1'b0; #1;
      chk("rst_rdata",  ReadData, 32'h1234_5678);
      #20 reset = 1'b1;
      tick();
      ALUResult = 32'h107; #1;
      chk("idle_empty", {31'b0, BufEmpty},  32'd1);
      chk("idle_wvld",  {31'b0, MemWValid}, 32'd0);
      chk("idle_stall", {31'b0, Stall},     32'd0);
      chk("idle_rdata", ReadData, 32'h1234_5678);
      chk("idle_radr",  MemRAdr,  32'h104);

      // 2. single store, forwarding with sub-word address
      MemRData = 32'h0;
      store(32'h100, 32'hDEAD_BEEF); #1;
      chk("t2_stall",   {31'b0, Stall},     32'd0);
      chk("t2_lat0",    {31'b0, MemWValid}, 32'd0);
      tick();
      MemWrite = 1'b0; ALUResult = 32'h102; #1;
      chk("t2_wvld",    {31'b0, MemWValid}, 32'd1);
      chk("t2_wadr",    MemWAdr,  32'h100);
      chk("t2_wdata",   MemWData, 32'hDEAD_BEEF);
      chk("t2_fwd",     ReadData, 32'hDEAD_BEEF);
      chk("t2_nempty",  {31'b0, BufEmpty},  32'd0);
      tick();
      chk("t2_hold_a",  MemWAdr,  32'h100);
      chk("t2_hold_d",  MemWData, 32'hDEAD_BEEF);
      exp_q.push_back({32'h100, 32'hDEAD_BEEF});
      MemWReady = 1'b1;
      tick();
      MemWReady = 1'b0; MemRData = 32'h55; #1;
      chk("t2_drained", {31'b0, BufEmpty},  32'd1);
      chk("t2_mem",     ReadData, 32'h55);

      // 3. same address twice: youngest forwards, both drain in order
      store(32'h40, 32'd1); tick();
      store(32'h40, 32'd2); tick();
      MemWrite = 1'b0; ALUResult = 32'h40; #1;
      chk("t3_fwd",     ReadData, 32'd2);
      chk("t3_count",   32'(dut.count_q), 32'd2);
      exp_q.push_back({32'h40, 32'd1});
      exp_q.push_back({32'h40, 32'd2});
      MemWReady = 1'b1; #1;
      chk("t3_fwd_pop", ReadData, 32'd2);
      tick();
      chk("t3_fwd_head", ReadData, 32'd2);
      tick();
      MemWReady = 1'b0; #1;
      chk("t3_empty",   {31'b0, BufEmpty},  32'd1);
      chk("t3_mem",     ReadData, 32'h55);

      // 4. fill to DEPTH, stall, release one slot
      for (int k = 0; k < 4; k++) begin
         store(32'h200 + 32'(4*k), 32'hA0 + 32'(k)); #1;
         chk("t4_nostall", {31'b0, Stall}, 32'd0);
         tick();
         exp_q.push_back({32'h200 + 32'(4*k), 32'hA0 + 32'(k)});
      end
      store(32'h210, 32'hA4); #1;
      chk("t4_stall",   {31'b0, Stall}, 32'd1);
      chk("t4_full",    32'(dut.count_q), 32'd4);
      tick();
      chk("t4_stall2",  {31'b0, Stall}, 32'd1);
      chk("t4_full2",   32'(dut.count_q), 32'd4);
      MemWReady = 1'b1; #1;
      chk("t4_stall_pop", {31'b0, Stall}, 32'd1);
      tick();
      MemWReady = 1'b0; #1;
      chk("t4_cnt3",    32'(dut.count_q), 32'd3);
      chk("t4_accept",  {31'b0, Stall}, 32'd0);
      tick();
      exp_q.push_back({32'h210, 32'hA4});
      MemWrite = 1'b0; ALUResult = 32'h20C; #1;
      chk("t4_cnt4",    32'(dut.count_q), 32'd4);
      chk("t4_fwd3",    ReadData, 32'hA3);
      ALUResult = 32'h210; #1;
      chk("t4_fwd4",    ReadData, 32'hA4);
      ALUResult = 32'h300; #1;
      chk("t4_nomatch", ReadData, 32'h55);
      MemWReady = 1'b1;
      for (int k = 0; k < 4; k++) tick();
      chk("t4_empty",   {31'b0, BufEmpty}, 32'd1);

      // 5. streaming with ready high: occupancy stays at one, pointers wrap
      for (int k = 0; k < 12; k++) begin
         store(32'h400 + 32'(4*k), 32'hC0 + 32'(k));
         tick();
         exp_q.push_back({32'h400 + 32'(4*k), 32'hC0 + 32'(k)});
         chk("t5_count", 32'(dut.count_q), 32'd1);
      end
      MemWrite = 1'b0;
      tick();
      chk("t5_empty",   {31'b0, BufEmpty}, 32'd1);

      // 6. reset with stores pending discards them
      MemWReady = 1'b0;
      for (int k = 0; k < 3; k++) begin
         store(32'h500 + 32'(4*k), 32'hE0 + 32'(k));
         tick();
      end
      MemWrite = 1'b0; ALUResult = 32'h500; #1;
      chk("t6_pending", {31'b0, MemWValid}, 32'd1);
      chk("t6_fwd",     ReadData, 32'hE0);
      reset = 1'b0; #1;
      chk("t6_wvld0",   {31'b0, MemWValid}, 32'd0);
      chk("t6_empty",   {31'b0, BufEmpty},  32'd1);
      chk("t6_rdata",   ReadData, 32'h55);
      tick();
      reset = 1'b1; MemWReady = 1'b1;
      for (int k = 0; k < 3; k++) tick();
      chk("t6_post_vld", {31'b0, MemWValid}, 32'd0);

      // memory channel order and exactly-once delivery
      chk("log_size", 32'(log_q.size()), 32'(exp_q.size()));
      for (int k = 0; k < exp_q.size() && k < log_q.size(); k++) begin
         chk("log_adr",  log_q[k][63:32], exp_q[k][63:32]);
         chk("log_data", log_q[k][31:0],  exp_q[k][31:0]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
